global_control: RTL and testbench

// Array-wide sequencer feeding every core_control instance. Owns the global

---
 rtl/isa.sv | 53 +++++
 rtl/global_control_if.sv | 37 +++
 rtl/global_control.sv | 130 +++++++++++++
 tb/tb_global_control.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/isa.sv
`default_nettype none
// ============================================================================
// Package     : isa
// Description : Instruction word layout, machine widths and the decode helpers
//               shared by the array sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package isa;

    localparam int program_counter_length = 8;
    localparam int stack_pointer_length   = 3;
    localparam int opcode_length          = 4;
    localparam int instruction_length     = opcode_length + program_counter_length;

    typedef logic [program_counter_length-1:0] pc_t;
    typedef logic [stack_pointer_length-1:0]   sp_t;
    typedef logic [instruction_length-1:0]     instruction_t;
    typedef logic [opcode_length-1:0]          opcode_t;

    localparam opcode_t c_OP_NOP         = 4'h0;
    localparam opcode_t c_OP_ALU         = 4'h1;
    localparam opcode_t c_OP_JUMP        = 4'h8;
    localparam opcode_t c_OP_BRANCH_COND = 4'h9;
    localparam opcode_t c_OP_CALL        = 4'hA;
    localparam opcode_t c_OP_RETURN      = 4'hB;

    function automatic opcode_t get_opcode(input instruction_t instr);
        return instr[instruction_length-1:program_counter_length];
    endfunction

    // The offset field is exactly PC-wide, so modular addition sign-extends it.
    function automatic pc_t get_relative_branch_addr(input instruction_t instr);
        return instr[program_counter_length-1:0];
    endfunction

    function automatic logic is_conditional_branch(input instruction_t instr);
        return get_opcode(instr) == c_OP_BRANCH_COND;
    endfunction

    function automatic logic is_call(input instruction_t instr);
        return get_opcode(instr) == c_OP_CALL;
    endfunction

    function automatic logic is_return(input instruction_t instr);
        return get_opcode(instr) == c_OP_RETURN;
    endfunction

    function automatic logic is_unconditional_branch(input instruction_t instr);
        return (get_opcode(instr) == c_OP_JUMP) || is_call(instr) || is_return(instr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/global_control_if.sv
`default_nettype none
// ============================================================================
// Interface   : global_control_if
// Description : Sequencer bundle between instruction memory, core array and
//               the global controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface global_control_if
    import isa::*;
#(
    parameter int NUM_CORES = 16
) ();

    instruction_t           instruction;
    logic [NUM_CORES-1:0]   diverge;
    pc_t                    program_counter;
    sp_t                    stack_pointer;
    pc_t                    next_program_counter;
    sp_t                    next_stack_pointer;
    logic                   global_enable;
    logic                   halted;
    logic                   fault;

    modport master (
        input  instruction, diverge,
        output program_counter, stack_pointer, next_program_counter,
               next_stack_pointer, global_enable, halted, fault
    );

    modport slave (
        output instruction, diverge,
        input  program_counter, stack_pointer, next_program_counter,
               next_stack_pointer, global_enable, halted, fault
    );

endinterface
`default_nettype wire

// File: rtl/global_control.sv
`default_nettype none
// ============================================================================
// Module      : global_control
// Description : Array-wide sequencer: global PC, call/return stack, branch
//               resolution from the diverge vector and deadlock detection.
// Revision    : 1.0 - initial release
// ============================================================================
module global_control
    import isa::*;
#(
    parameter int NUM_CORES   = 16,
    parameter int STACK_DEPTH = 2**stack_pointer_length
) (
    input  wire logic         clk,
    input  wire logic         rst,
    global_control_if.master  bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam sp_t c_SP_FULL = sp_t'(STACK_DEPTH - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    pc_t                    r_pc;
    pc_t                    w_next_pc;
    sp_t                    r_sp;
    sp_t                    w_next_sp;
    logic                   r_halted;
    logic                   r_fault;
    pc_t                    r_stack [STACK_DEPTH];

    logic [NUM_CORES-1:0]   w_diverge;
    logic                   w_all_diverge;
    logic                   w_is_cond;
    logic                   w_is_uncond;
    logic                   w_is_call;
    logic                   w_is_return;
    pc_t                    w_target;
    pc_t                    w_pc_inc;
    logic                   w_push;
    logic                   w_enable;

    assign w_diverge     = bus.diverge;
    assign w_all_diverge = &w_diverge;
    assign w_is_cond     = is_conditional_branch(bus.instruction);
    assign w_is_uncond   = is_unconditional_branch(bus.instruction);
    assign w_is_call     = is_call(bus.instruction);
    assign w_is_return   = is_return(bus.instruction);
    assign w_target      = r_pc + get_relative_branch_addr(bus.instruction);
    assign w_pc_inc      = r_pc + pc_t'(1);

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_sp    = r_sp;
        w_push       = 1'b0;
        w_enable     = 1'b0;
        if (r_state == RUN) begin
            w_enable = 1'b1;
            // Every core waiting on something other than a branch can never resolve.
            if (w_all_diverge && !w_is_cond) begin
                w_next_state = FAULT;
                w_enable     = 1'b0;
            end else if (w_is_cond) begin
                w_next_pc = w_all_diverge ? w_target : w_pc_inc;
            end else if (w_is_call) begin
                if (r_sp == c_SP_FULL) begin
                    w_next_state = FAULT;
                    w_enable     = 1'b0;
                end else begin
                    w_push    = 1'b1;
                    w_next_sp = r_sp + sp_t'(1);
                    w_next_pc = w_target;
                end
            end else if (w_is_return) begin
                if (r_sp == '0) begin
                    w_next_state = HALT;
                    w_enable     = 1'b0;
                end else begin
                    w_next_sp = r_sp - sp_t'(1);
                    w_next_pc = r_stack[r_sp - sp_t'(1)];
                end
            end else if (w_is_uncond) begin
                w_next_pc = w_target;
            end else begin
                w_next_pc = w_pc_inc;
            end
        end
        if (rst) begin
            w_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_pc     <= '0;
            r_sp     <= '0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_pc     <= w_next_pc;
            r_sp     <= w_next_sp;
            r_halted <= (w_next_state == HALT);
            r_fault  <= (w_next_state == FAULT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_stack[r_sp] <= w_pc_inc;
        end
    end

    assign bus.program_counter      = r_pc;
    assign bus.stack_pointer        = r_sp;
    assign bus.next_program_counter = w_next_pc;
    assign bus.next_stack_pointer   = w_next_sp;
    assign bus.global_enable        = w_enable;
    assign bus.halted               = r_halted;
    assign bus.fault                = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_global_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_global_control
// Description : Randomised and directed programs against a queue-stack model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_global_control;
    import isa::*;

    localparam int NC    = 16;
    localparam int DEPTH = 2**stack_pointer_length;
    localparam int PCMOD = 2**program_counter_length;

    typedef struct {
        bit chk_state;
        bit chk_next;
        bit chk_en;
        int pc;
        int sp;
        int npc;
        int nsp;
        int en;
        int halted;
        int fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    global_control_if #(.NUM_CORES(NC)) bus ();

    global_control #(.NUM_CORES(NC), .STACK_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          sb [$];
    int            vectors     = 0;
    int            miscompares = 0;
    instruction_t  mem [PCMOD];
    int            m_pc        = 0;
    int            m_status    = 0;   // 0 running, 1 halted, 2 faulted
    int            m_stack [$];
    bit            m_known     = 1'b0;

    function automatic instruction_t mk(input opcode_t op, input int rel);
        return {op, pc_t'(rel)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides the architectural effect.
    task automatic cycle(input logic r, input logic [NC-1:0] d);
        exp_t         e;
        instruction_t ins;
        int           op, rel, tgt, inc;
        bit           all;
        @(posedge clk);
        #1;
        ins             = mem[m_pc];
        rst             = r;
        bus.diverge     = d;
        bus.instruction = ins;
        op  = int'(ins[instruction_length-1:program_counter_length]);
        rel = int'($signed(ins[program_counter_length-1:0]));
        tgt = ((m_pc + rel) % PCMOD + PCMOD) % PCMOD;
        inc = (m_pc + 1) % PCMOD;
        all = (d == {NC{1'b1}});
        e.chk_state = m_known;
        e.chk_next  = m_known && !r;
        e.chk_en    = m_known || r;
        e.pc        = m_pc;
        e.sp        = m_stack.size();
        e.halted    = (m_status == 1);
        e.fault     = (m_status == 2);
        e.en        = 0;
        if (r) begin
            m_pc     = 0;
            m_stack.delete();
            m_status = 0;
            m_known  = 1'b1;
        end else if (m_known && m_status == 0) begin
            e.en = 1;
            if (all && op != int'(c_OP_BRANCH_COND)) begin
                m_status = 2;
                e.en     = 0;
            end else if (op == int'(c_OP_BRANCH_COND)) begin
                m_pc = all ? tgt : inc;
            end else if (op == int'(c_OP_CALL)) begin
                if (m_stack.size() == DEPTH - 1) begin
                    m_status = 2;
                    e.en     = 0;
                end else begin
                    m_stack.push_back(inc);
                    m_pc = tgt;
                end
            end else if (op == int'(c_OP_RETURN)) begin
                if (m_stack.size() == 0) begin
                    m_status = 1;
                    e.en     = 0;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end else if (op == int'(c_OP_JUMP)) begin
                m_pc = tgt;
            end else begin
                m_pc = inc;
            end
        end
        e.npc = m_pc;
        e.nsp = m_stack.size();
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_en)    chk("global_enable", 32'(bus.global_enable), e.en);
            if (e.chk_state) begin
                chk("program_counter", 32'(bus.program_counter), e.pc);
                chk("stack_pointer",   32'(bus.stack_pointer),   e.sp);
                chk("halted",          32'(bus.halted),          e.halted);
                chk("fault",           32'(bus.fault),           e.fault);
            end
            if (e.chk_next) begin
                chk("next_program_counter", 32'(bus.next_program_counter), e.npc);
                chk("next_stack_pointer",   32'(bus.next_stack_pointer),   e.nsp);
            end
        end
    end

    task automatic fill(input instruction_t v);
        for (int i = 0; i < PCMOD; i++) mem[i] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [NC-1:0] d;
        int            sel;
        rst             = 1'b1;
        bus.diverge     = '0;
        bus.instruction = '0;
        fill(mk(c_OP_NOP, 0));

        // Straight-line NOPs.
        cycle(1'b1, '0);
        repeat (6) cycle(1'b0, '0);

        // Conditional branch at 10, offset -4: taken then not taken.
        mem[10] = mk(c_OP_BRANCH_COND, -4);
        cycle(1'b1, '0);
        repeat (10) cycle(1'b0, '0);
        cycle(1'b0, {NC{1'b1}});
        repeat (4) cycle(1'b0, '0);
        cycle(1'b0, NC'(1));
        repeat (2) cycle(1'b0, '0);

        // Call at 20 to 50, return to 21, return from top level halts.
        fill(mk(c_OP_NOP, 0));
        mem[0]  = mk(c_OP_JUMP, 20);
        mem[20] = mk(c_OP_CALL, 30);
        mem[50] = mk(c_OP_RETURN, 0);
        mem[21] = mk(c_OP_RETURN, 0);
        cycle(1'b1, '0);
        repeat (7) cycle(1'b0, '0);

        // Nested calls until the stack is full, then recover with reset.
        fill(mk(c_OP_CALL, 1));
        cycle(1'b1, '0);
        repeat (DEPTH + 3) cycle(1'b0, '0);
        cycle(1'b1, '0);
        repeat (2) cycle(1'b0, '0);

        // Deadlock on a NOP.
        fill(mk(c_OP_NOP, 0));
        cycle(1'b1, '0);
        cycle(1'b0, '0);
        cycle(1'b0, {NC{1'b1}});
        repeat (3) cycle(1'b0, '0);

        // PC wrap at the top of memory, then reset during a jump.
        mem[0] = mk(c_OP_JUMP, -1);
        cycle(1'b1, '0);
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        cycle(1'b1, '0);
        repeat (3) cycle(1'b0, '0);

        // Random programs and diverge patterns.
        for (int ep = 0; ep < 40; ep++) begin
            for (int i = 0; i < PCMOD; i++) begin
                sel = int'($urandom_range(0, 9));
                case (sel)
                    3:       mem[i] = mk(c_OP_ALU, 0);
                    4, 5:    mem[i] = mk(c_OP_BRANCH_COND, int'($urandom_range(0, 16)) - 8);
                    6:       mem[i] = mk(c_OP_JUMP, int'($urandom_range(0, 16)) - 8);
                    7:       mem[i] = mk(c_OP_CALL, int'($urandom_range(0, 40)) - 20);
                    8:       mem[i] = mk(c_OP_RETURN, 0);
                    default: mem[i] = mk(c_OP_NOP, 0);
                endcase
            end
            cycle(1'b1, '0);
            for (int c = 0; c < 60; c++) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 6)      d = '0;
                else if (sel < 8) d = {NC{1'b1}};
                else              d = NC'($urandom);
                cycle(($urandom_range(0, 39) == 0), d);
            end
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
